// File: rtl/carfield_domain_seq.sv
// carfield_domain_seq
// -------------------
// Power/clock/reset sequencer for the Carfield accelerator islands
// (domain 0 safety island, 1 integer cluster, 2 FP cluster). Each domain
// runs its own FSM and counter. Power-up order is: clock enable, reset
// release, AXI de-isolation. Power-down runs in the reverse order. If the
// isolation handshake stalls, a timeout sets a sticky error and the domain
// is forced back to OFF.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous, active-high reset
//   en_req_i    per-domain level request (1 = on, 0 = off)
//   isolated_i  per-domain isolation status from the AXI isolate wrapper
//   clr_err_i   per-domain single-cycle pulse that clears err_o
//   isolate_o   per-domain AXI isolation request (1 = isolated)
//   clk_en_o    per-domain clock-gate enable
//   rst_no      per-domain active-low reset
//   busy_o      per-domain "sequence in progress" (not OFF and not ON)
//   err_o       per-domain sticky handshake-timeout flag
//   state_o     per-domain FSM state; domain d occupies [3d+2:3d]

module carfield_domain_seq #(
    parameter int unsigned NumDomains = 3,
    parameter int unsigned ClkSettle  = 4,
    parameter int unsigned RstCycles  = 8,
    parameter int unsigned IsoTimeout = 255,
    parameter int unsigned CntWidth   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumDomains-1:0]   en_req_i,
    input  logic [NumDomains-1:0]   isolated_i,
    input  logic [NumDomains-1:0]   clr_err_i,
    output logic [NumDomains-1:0]   isolate_o,
    output logic [NumDomains-1:0]   clk_en_o,
    output logic [NumDomains-1:0]   rst_no,
    output logic [NumDomains-1:0]   busy_o,
    output logic [NumDomains-1:0]   err_o,
    output logic [3*NumDomains-1:0] state_o
);

    typedef enum logic [2:0] {
        StOff       = 3'd0,
        StClkOn     = 3'd1,
        StRstHold   = 3'd2,
        StDeiso     = 3'd3,
        StOn        = 3'd4,
        StIso       = 3'd5,
        StRstAssert = 3'd6,
        StClkOff    = 3'd7
    } state_e;

    localparam logic [CntWidth-1:0] ClkSettleLoad = CntWidth'(ClkSettle - 1);
    localparam logic [CntWidth-1:0] RstCyclesLoad = CntWidth'(RstCycles - 1);
    localparam logic [CntWidth-1:0] IsoTimeLoad   = CntWidth'(IsoTimeout - 1);
    localparam logic [CntWidth-1:0] CntZero       = '0;
    localparam logic [CntWidth-1:0] CntOne        = CntWidth'(1);

    // Output decode per state, packed as {isolate, clk_en, rst_n}.
    function automatic logic [2:0] decodeOut(state_e s);
        logic [2:0] o;
        o = 3'b100;
        case (s)
            StOff:       o = 3'b100;
            StClkOn:     o = 3'b110;
            StRstHold:   o = 3'b110;
            StDeiso:     o = 3'b011;
            StOn:        o = 3'b011;
            StIso:       o = 3'b111;
            StRstAssert: o = 3'b110;
            StClkOff:    o = 3'b100;
            default:     o = 3'b100;
        endcase
        return o;
    endfunction

    for (genvar d = 0; d < NumDomains; d++) begin : gen_dom
        state_e              state_q, state_d;
        logic [CntWidth-1:0] cnt_q, cnt_d;
        logic                err_q, err_d;
        logic                setErr;
        logic                iso_q, clkEn_q, rstN_q, busy_q;

        // Next-state logic for one domain. A single counter serves every
        // timed phase; each phase loads it on entry and counts down to 0.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            setErr  = 1'b0;
            case (state_q)
                StOff: begin
                    if (en_req_i[d] && !err_q) begin
                        state_d = StClkOn;
                        cnt_d   = ClkSettleLoad;
                    end
                end
                StClkOn: begin
                    if (cnt_q == CntZero) begin
                        state_d = StRstHold;
                        cnt_d   = RstCyclesLoad;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StRstHold: begin
                    if (cnt_q == CntZero) begin
                        state_d = StDeiso;
                        cnt_d   = IsoTimeLoad;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StDeiso: begin
                    // A matching handshake on the last counter cycle still wins.
                    if (!isolated_i[d]) begin
                        state_d = StOn;
                    end else if (cnt_q == CntZero) begin
                        setErr  = 1'b1;
                        state_d = StIso;
                        cnt_d   = IsoTimeLoad;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StOn: begin
                    if (!en_req_i[d]) begin
                        state_d = StIso;
                        cnt_d   = IsoTimeLoad;
                    end
                end
                StIso: begin
                    if (isolated_i[d]) begin
                        state_d = StRstAssert;
                    end else if (cnt_q == CntZero) begin
                        setErr  = 1'b1;
                        state_d = StRstAssert;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StRstAssert: state_d = StClkOff;
                StClkOff:    state_d = StOff;
                default:     state_d = StOff;
            endcase
            // A timeout in the same cycle as a clear request keeps the error.
            err_d = setErr ? 1'b1 : (clr_err_i[d] ? 1'b0 : err_q);
        end

        // State, counter, error flag and the Moore outputs all register here.
        // The outputs are decoded from the next state so they line up with
        // state_q in the same cycle without any input-to-output path.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= StOff;
                cnt_q   <= CntZero;
                err_q   <= 1'b0;
                iso_q   <= 1'b1;
                clkEn_q <= 1'b0;
                rstN_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q                   <= state_d;
                cnt_q                     <= cnt_d;
                err_q                     <= err_d;
                {iso_q, clkEn_q, rstN_q}  <= decodeOut(state_d);
                busy_q                    <= (state_d != StOff) && (state_d != StOn);
            end
        end

        assign isolate_o[d]      = iso_q;
        assign clk_en_o[d]       = clkEn_q;
        assign rst_no[d]         = rstN_q;
        assign busy_o[d]         = busy_q;
        assign err_o[d]          = err_q;
        assign state_o[3*d +: 3] = state_q;
    end

endmodule
